// File: rtl/io_bridge_pkg.sv
// Shared types for the processor I/O bridge.
package io_bridge_pkg;
  `include "io_bridge_defs.vh"

  // Interrupt generator states: wait for data, pulse, enforce the gap.
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FIRE = ST_FIRE,
    HOLD = ST_HOLD
  } itr_state_e;
endpackage

// File: rtl/io_bridge_defs.vh
// Interrupt FSM state encodings shared by the io_bridge package.
`ifndef IO_BRIDGE_DEFS_VH
`define IO_BRIDGE_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_FIRE = 2'd1;
localparam logic [1:0] ST_HOLD = 2'd2;
`endif

// File: rtl/io_hold_reg.sv
// Single-word holding register with a full flag; load wins over clear.
module io_hold_reg #(
  parameter int NUBITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NUBITS-1:0] d,
  input  logic              clr,
  output logic [NUBITS-1:0] q,
  output logic              full
);
  logic [NUBITS-1:0] data_q, data_d;
  logic              full_q, full_d;

  // Next state: load captures a word and marks full; clear only drops the flag.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (clr) begin
      full_d = 1'b0;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;
endmodule

// File: rtl/io_bridge.sv
// Peripheral-side responder for the processor I/O bus: buffers input and
// output streams in holding registers and raises a rate-limited interrupt.
// Streams: a word moves when valid && ready are both high at a clock edge;
// in_ready depends only on the holding flag, out_valid is the holding flag.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int ITREN  = 1,
  parameter int ITRGAP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [NUBITS-1:0]         cpu_io_in,
  input  logic [NUBITS-1:0]         cpu_io_out,
  input  logic [$clog2(NUIOIN)-1:0] cpu_addr_in,
  input  logic [$clog2(NUIOOU)-1:0] cpu_addr_out,
  input  logic                      cpu_req_in,
  input  logic                      cpu_out_en,
  output logic                      cpu_itr,
  input  logic [NUIOIN*NUBITS-1:0]  in_data,
  input  logic [NUIOIN-1:0]         in_valid,
  output logic [NUIOIN-1:0]         in_ready,
  output logic [NUIOOU*NUBITS-1:0]  out_data,
  output logic [NUIOOU-1:0]         out_valid,
  input  logic [NUIOOU-1:0]         out_ready,
  output logic [NUIOIN-1:0]         in_unf,
  output logic [NUIOOU-1:0]         out_ovf
);
  localparam int CW = (ITRGAP > 2) ? $clog2(ITRGAP) : 1;

  logic [NUIOIN-1:0][NUBITS-1:0] in_word;
  logic [NUIOOU-1:0][NUBITS-1:0] out_word;
  logic [NUIOIN-1:0] in_full, in_load, in_clr;
  logic [NUIOOU-1:0] out_full, out_load, out_clr;
  logic [NUIOIN-1:0] unf_q, unf_d;
  logic [NUIOOU-1:0] ovf_q, ovf_d;

  itr_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              itr_q, itr_d;
  logic              ev;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    io_hold_reg #(.NUBITS(NUBITS)) u_in (
      .clk  (clk),
      .rst  (rst),
      .load (in_load[k]),
      .d    (in_data[k*NUBITS +: NUBITS]),
      .clr  (in_clr[k]),
      .q    (in_word[k]),
      .full (in_full[k])
    );
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    io_hold_reg #(.NUBITS(NUBITS)) u_out (
      .clk  (clk),
      .rst  (rst),
      .load (out_load[j]),
      .d    (cpu_io_out),
      .clr  (out_clr[j]),
      .q    (out_word[j]),
      .full (out_full[j])
    );
  end

  assign in_ready  = ~in_full;
  assign out_valid = out_full;
  assign out_data  = out_word;
  assign in_unf    = unf_q;
  assign out_ovf   = ovf_q;

  // Read mux, read consumption and underflow detection on the input side.
  always_comb begin
    cpu_io_in = '0;
    in_load   = in_valid & ~in_full;
    in_clr    = '0;
    unf_d     = unf_q;
    for (int k = 0; k < NUIOIN; k++) begin
      if (int'(cpu_addr_in) == k) begin
        cpu_io_in = in_word[k];
        if (cpu_req_in) begin
          in_clr[k] = in_full[k];
          if (!in_full[k]) unf_d[k] = 1'b1;
        end
      end
    end
  end

  // Write decode, drain and overwrite detection on the output side.
  always_comb begin
    out_load = '0;
    out_clr  = out_full & out_ready;
    ovf_d    = ovf_q;
    for (int j = 0; j < NUIOOU; j++) begin
      if (cpu_out_en && (int'(cpu_addr_out) == j)) begin
        out_load[j] = 1'b1;
        if (out_full[j] && !out_ready[j]) ovf_d[j] = 1'b1;
      end
    end
  end

  // A load into an empty input register is the 0->1 edge of its full flag.
  assign ev = (ITREN != 0) && (|in_load);

  // Interrupt FSM next state: one-cycle pulse, then a hold-off window that
  // collapses any events seen meanwhile into a single follow-up pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: if (ev) state_d = FIRE;
      FIRE: begin
        state_d = HOLD;
        cnt_d   = CW'(ITRGAP - 2);
        pend_d  = pend_q | ev;
      end
      HOLD: begin
        pend_d = pend_q | ev;
        if (cnt_q == '0) begin
          state_d = (pend_q | ev) ? FIRE : IDLE;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    itr_d = (state_d == FIRE);
  end

  // Sticky flags and interrupt FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      unf_q   <= '0;
      ovf_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      itr_q   <= 1'b0;
    end else begin
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      itr_q   <= itr_d;
    end
  end

  assign cpu_itr = (ITREN != 0) ? itr_q : 1'b0;
endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: one instance with the interrupt enabled and
// one with it disabled, both driven by the same stimulus.
module tb_io_bridge;
  import io_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_io_out;
  logic [0:0]  cpu_addr_in, cpu_addr_out;
  logic        cpu_req_in, cpu_out_en;
  logic [31:0] in_data;
  logic [1:0]  in_valid, out_ready;

  logic [15:0] io_in0, io_in1;
  logic        itr0, itr1;
  logic [1:0]  in_ready0, in_ready1, out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [1:0]  unf0, unf1, ovf0, ovf1;

  int checks = 0;
  int errors = 0;
  int itr_cnt = 0;
  int itr1_cnt = 0;
  logic [20:0] exp_itr;

  io_bridge #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .ITREN(1), .ITRGAP(8)) dut0 (
    .clk(clk), .rst(rst), .cpu_io_in(io_in0), .cpu_io_out(cpu_io_out),
    .cpu_addr_in(cpu_addr_in), .cpu_addr_out(cpu_addr_out),
    .cpu_req_in(cpu_req_in), .cpu_out_en(cpu_out_en), .cpu_itr(itr0),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .in_unf(unf0), .out_ovf(ovf0)
  );

  io_bridge #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .ITREN(0), .ITRGAP(8)) dut1 (
    .clk(clk), .rst(rst), .cpu_io_in(io_in1), .cpu_io_out(cpu_io_out),
    .cpu_addr_in(cpu_addr_in), .cpu_addr_out(cpu_addr_out),
    .cpu_req_in(cpu_req_in), .cpu_out_en(cpu_out_en), .cpu_itr(itr1),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .in_unf(unf1), .out_ovf(ovf1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interrupt-disabled instance must never pulse.
  always @(negedge clk) if (itr1) itr1_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Count interrupt pulses over n cycles.
  task automatic count_itr(input int n);
    itr_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (itr0) itr_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; cpu_io_out = '0; cpu_addr_in = '0; cpu_addr_out = '0;
    cpu_req_in = 1'b0; cpu_out_en = 1'b0; in_data = '0; in_valid = '0; out_ready = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready0), 32'h3);
    check_eq("rst_out_valid", 32'(out_valid0), 32'h0);
    check_eq("rst_itr", 32'(itr0), 32'h0);
    check_eq("rst_unf", 32'(unf0), 32'h0);
    check_eq("rst_ovf", 32'(ovf0), 32'h0);
    check_eq("rst_state", 32'(dut0.state_q), 32'(IDLE));

    // Underflow: read empty channel 0
    cpu_addr_in = 1'b0; cpu_req_in = 1'b1;
    #1 check_eq("unf_rdata", 32'(io_in0), 32'h0);
    tick();
    cpu_req_in = 1'b0;
    check_eq("unf_flag", 32'(unf0), 32'h1);
    check_eq("unf_ready", 32'(in_ready0), 32'h3);

    // Input word on channel 1 and its interrupt
    in_data = {16'h1234, 16'h0000}; in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    check_eq("in_full", 32'(in_ready0), 32'h1);
    check_eq("itr_pulse", 32'(itr0), 32'h1);
    tick();
    check_eq("itr_end", 32'(itr0), 32'h0);
    count_itr(10);
    check_eq("itr_single", 32'(itr_cnt), 32'h0);

    // Processor read of channel 1
    cpu_addr_in = 1'b1; cpu_req_in = 1'b1;
    #1 check_eq("rd_data", 32'(io_in0), 32'h1234);
    tick();
    cpu_req_in = 1'b0;
    check_eq("rd_ready", 32'(in_ready0), 32'h3);
    check_eq("unf_sticky", 32'(unf0), 32'h1);

    // Interrupt hold-off: ch0 fill, ch1 fill three cycles later
    exp_itr = '0;
    exp_itr[1] = 1'b1;
    exp_itr[9] = 1'b1;
    in_data = {16'h5678, 16'h9abc};
    for (int i = 0; i <= 20; i++) begin
      check_eq($sformatf("holdoff_t%0d", i), 32'(itr0), 32'(exp_itr[i]));
      if (i == 0) in_valid = 2'b01;
      if (i == 1) in_valid = 2'b00;
      if (i == 3) in_valid = 2'b10;
      if (i == 4) in_valid = 2'b00;
      tick();
    end
    check_eq("both_full", 32'(in_ready0), 32'h0);

    // Output collision on channel 0
    out_ready = 2'b00; cpu_out_en = 1'b1; cpu_addr_out = 1'b0; cpu_io_out = 16'h00AA;
    tick();
    cpu_io_out = 16'h00BB;
    check_eq("wr_valid", 32'(out_valid0), 32'h1);
    check_eq("wr_no_ovf", 32'(ovf0), 32'h0);
    tick();
    cpu_out_en = 1'b0;
    check_eq("ovw_data", 32'(out_data0[15:0]), 32'h00BB);
    check_eq("ovw_ovf", 32'(ovf0), 32'h1);

    // Write and drain in the same cycle on channel 0
    cpu_out_en = 1'b1; cpu_io_out = 16'h00CC; out_ready = 2'b01;
    tick();
    cpu_out_en = 1'b0; out_ready = 2'b00;
    check_eq("wd0_data", 32'(out_data0[15:0]), 32'h00CC);
    check_eq("wd0_valid", 32'(out_valid0), 32'h1);

    // Write and drain on channel 1, which has never overflowed
    cpu_out_en = 1'b1; cpu_addr_out = 1'b1; cpu_io_out = 16'h0011;
    tick();
    cpu_io_out = 16'h0022; out_ready = 2'b10;
    tick();
    cpu_out_en = 1'b0; out_ready = 2'b00;
    check_eq("wd1_data", 32'(out_data0[31:16]), 32'h0022);
    check_eq("wd1_valid", 32'(out_valid0), 32'h3);
    check_eq("wd1_ovf", 32'(ovf0), 32'h1);

    // Plain drain of channel 0
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    check_eq("drain", 32'(out_valid0), 32'h2);

    // Reset in the middle of a hold-off window with output pending
    cpu_addr_in = 1'b1; cpu_req_in = 1'b1;
    #1 check_eq("rd_ch1", 32'(io_in0), 32'h5678);
    tick();
    cpu_req_in = 1'b0; in_data = {16'h4321, 16'h0000}; in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    check_eq("mid_itr", 32'(itr0), 32'h1);
    tick();
    check_eq("mid_hold", 32'(dut0.state_q), 32'(HOLD));
    check_eq("mid_ovalid", 32'(out_valid0), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_ovalid", 32'(out_valid0), 32'h0);
    check_eq("mrst_ready", 32'(in_ready0), 32'h3);
    check_eq("mrst_unf", 32'(unf0), 32'h0);
    check_eq("mrst_ovf", 32'(ovf0), 32'h0);
    check_eq("mrst_state", 32'(dut0.state_q), 32'(IDLE));
    check_eq("mrst_rdata", 32'(io_in0), 32'h0);
    count_itr(12);
    check_eq("mrst_no_itr", 32'(itr_cnt), 32'h0);

    // Disabled interrupt instance stayed quiet throughout
    check_eq("itren0", 32'(itr1_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
